// File: rtl/status_framer.sv
// status_framer: snapshots CPU debug state on request and streams it as a UART byte frame.
// Define STATUS_FRAMER_CHECKSUM_EN to append an XOR checksum byte to every frame.
module status_framer #(
  parameter int         WORD_COUNT = 7,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     req_i,
  input  logic [15:0]              state_i,
  input  logic [7:0]               flags_i,
  input  logic [32*WORD_COUNT-1:0] words_i,
  input  logic                     tx_complete_i,
  output logic                     tx_en_o,
  output logic [7:0]               tx_byte_o,
  output logic                     busy_o,
  output logic                     done_o
);
`ifdef STATUS_FRAMER_CHECKSUM_EN
  localparam int FRAME_LEN = 5 + 4 * WORD_COUNT;
`else
  localparam int FRAME_LEN = 4 + 4 * WORD_COUNT;
`endif
  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} fsm_t;
  fsm_t fsm, fsm_nxt;
  logic [IW-1:0] idx;
  logic [15:0] snap_state;
  logic [7:0] snap_flags;
  logic [32*WORD_COUNT-1:0] snap_words;
  logic [7:0] byte_q, cur_byte;
  logic tc_q, tc_rise;
  logic [8*FRAME_LEN-1:0] frame;
  // Byte i of the frame lives at frame[8i+7:8i]; words are already little-endian packed.
`ifdef STATUS_FRAMER_CHECKSUM_EN
  logic [7:0] csum;
  assign frame = {csum, snap_words, snap_flags, snap_state[7:0], snap_state[15:8], HEADER};
`else
  assign frame = {snap_words, snap_flags, snap_state[7:0], snap_state[15:8], HEADER};
`endif
  assign cur_byte  = frame[{idx, 3'b000} +: 8];
  assign tc_rise   = tx_complete_i & ~tc_q;
  assign tx_en_o   = fsm != SEND;
  assign tx_byte_o = fsm == SEND ? cur_byte : byte_q;
  assign busy_o    = fsm == SEND || fsm == WAIT;
  assign done_o    = fsm == DONE;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) fsm <= IDLE;
    else fsm <= fsm_nxt;
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    fsm_nxt = req_i ? SEND : IDLE;
      SEND:    fsm_nxt = WAIT;
      WAIT:    fsm_nxt = tc_rise ? (idx == LAST ? DONE : SEND) : WAIT;
      default: fsm_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      idx        <= '0;
      tc_q       <= 1'b0;
      byte_q     <= 8'h00;
      snap_state <= '0;
      snap_flags <= '0;
      snap_words <= '0;
`ifdef STATUS_FRAMER_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      tc_q <= tx_complete_i;
      if (fsm == IDLE && req_i) begin
        snap_state <= state_i;
        snap_flags <= flags_i;
        snap_words <= words_i;
        idx        <= '0;
`ifdef STATUS_FRAMER_CHECKSUM_EN
        csum       <= 8'h00;
`endif
      end
      if (fsm == SEND) begin
        byte_q <= cur_byte;
`ifdef STATUS_FRAMER_CHECKSUM_EN
        csum   <= csum ^ cur_byte;
`endif
      end
      if (fsm == WAIT && tc_rise && idx != LAST) idx <= idx + 1'b1;
    end
endmodule

// File: tb/tb_status_framer.sv
// tb_status_framer: randomized frame traffic against a byte-list reference model of the framer.
module tb_status_framer;
  localparam int WC = 3;
  localparam logic [7:0] HDR = 8'hA5;
  logic clk = 0, reset_n = 0, req_i = 0, man_tc = 0, auto_tc = 0, uart_on = 1;
  logic [15:0] state_i = '0;
  logic [7:0] flags_i = '0;
  logic [32*WC-1:0] words_i = '0;
  logic tx_complete, tx_en_o, busy_o, done_o;
  logic [7:0] tx_byte_o;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int checks = 0, errors = 0, dones = 0;
  assign tx_complete = uart_on ? auto_tc : man_tc;
  status_framer #(.WORD_COUNT(WC), .HEADER(HDR)) dut (
    .clk_i(clk), .reset_i(reset_n), .req_i(req_i), .state_i(state_i), .flags_i(flags_i),
    .words_i(words_i), .tx_complete_i(tx_complete), .tx_en_o(tx_en_o), .tx_byte_o(tx_byte_o),
    .busy_o(busy_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!tx_en_o) got.push_back(tx_byte_o);
    if (done_o) dones++;
  end
  initial begin
    forever begin
      @(negedge clk);
      if (uart_on && !tx_en_o) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 auto_tc = 1;
        @(posedge clk);
        #1 auto_tc = 0;
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic build(input logic [15:0] s, input logic [7:0] f, input logic [32*WC-1:0] w);
    logic [7:0] x;
    exp_q = {};
    exp_q.push_back(HDR);
    exp_q.push_back(s[15:8]);
    exp_q.push_back(s[7:0]);
    exp_q.push_back(f);
    for (int k = 0; k < WC; k++)
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (32 * k + 8 * b)));
`ifdef STATUS_FRAMER_CHECKSUM_EN
    x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
`endif
  endtask
  function automatic logic [32*WC-1:0] rand_words();
    logic [32*WC-1:0] w;
    for (int k = 0; k < WC; k++) w = {w[32*WC-33:0], 32'($urandom)};
    return w;
  endfunction
  task automatic pulse_req();
    @(negedge clk);
    req_i = 1;
    @(negedge clk);
    req_i = 0;
  endtask
  task automatic run_frame(input logic [15:0] s, input logic [7:0] f, input logic [32*WC-1:0] w,
                           input int mode);
    int d0, bad;
    bit ok;
    build(s, f, w);
    state_i = s;
    flags_i = f;
    words_i = w;
    got = {};
    d0 = dones;
    bad = 0;
    ok = 0;
    pulse_req();
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (done_o) ok = 1;
      else begin
        if (!busy_o) bad++;
        if (mode == 1) begin
          state_i = 16'($urandom);
          flags_i = 8'($urandom);
          words_i = rand_words();
          req_i = $urandom_range(0, 3) == 0;
        end
        if (mode == 2 && i == 1) words_i = '0;
        @(negedge clk);
      end
    end
    req_i = 0;
    check("done_seen", 32'(ok), 1);
    check("busy_held", bad, 0);
    repeat (8) @(negedge clk);
    check("done_count", dones - d0, 1);
    check("frame_len", got.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got.size(); k++)
      check($sformatf("byte%0d", k), 32'(got[k]), 32'(exp_q[k]));
    check("byte_hold", 32'(tx_byte_o), 32'(exp_q[exp_q.size()-1]));
  endtask
  initial begin
    logic [7:0] ref8[8];
    int d0, n;
    ref8 = '{8'hA5, 8'h12, 8'h34, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    repeat (3) @(negedge clk);
    check("rst_tx_en", 32'(tx_en_o), 1);
    check("rst_byte", 32'(tx_byte_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    reset_n = 1;
    repeat (2) @(negedge clk);
    run_frame(16'h1234, 8'h80, {{(32*WC-32){1'b0}}, 32'hDEADBEEF}, 2);
    for (int k = 0; k < 8; k++) check($sformatf("vec%0d", k), 32'(got[k]), 32'(ref8[k]));
    for (int r = 0; r < 10; r++) run_frame(16'($urandom), 8'($urandom), rand_words(), r % 2);
    uart_on = 0;
    man_tc = 0;
    state_i = 16'($urandom);
    flags_i = 8'($urandom);
    words_i = rand_words();
    build(state_i, flags_i, words_i);
    got = {};
    d0 = dones;
    pulse_req();
    repeat (3) @(negedge clk);
    check("hold_first", got.size(), 1);
    man_tc = 1;
    repeat (20) @(negedge clk);
    check("hold_high", got.size(), 2);
    man_tc = 0;
    repeat (2) @(negedge clk);
    man_tc = 1;
    repeat (2) @(negedge clk);
    check("hold_reedge", got.size(), 3);
    for (int i = 0; i < exp_q.size() - 2; i++) begin
      man_tc = 0;
      @(negedge clk);
      man_tc = 1;
      @(negedge clk);
    end
    man_tc = 0;
    repeat (4) @(negedge clk);
    check("hold_done", dones - d0, 1);
    check("hold_len", got.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got.size(); k++)
      check($sformatf("hold_byte%0d", k), 32'(got[k]), 32'(exp_q[k]));
    uart_on = 1;
    state_i = 16'($urandom);
    words_i = rand_words();
    got = {};
    pulse_req();
    for (int i = 0; i < 4000 && got.size() < 6; i++) @(negedge clk);
    check("reach_byte5", got.size(), 6);
    @(posedge clk);
    #1 reset_n = 0;
    #1;
    check("mid_rst_tx_en", 32'(tx_en_o), 1);
    check("mid_rst_byte", 32'(tx_byte_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_done", 32'(done_o), 0);
    n = got.size();
    repeat (6) @(negedge clk);
    check("rst_no_strobe", got.size(), n);
    reset_n = 1;
    repeat (8) @(negedge clk);
    check("rst_no_restart", got.size(), n);
    run_frame(16'($urandom), 8'($urandom), rand_words(), 0);
    check("first_after_rst", 32'(got[0]), 32'(HDR));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
